axi4l_mst_bridge: RTL and testbench



---
 rtl/axi4l_mst_bridge_pkg.sv | 26 ++
 rtl/axi4l_mst_bridge_if.sv | 42 ++++
 rtl/axi4l_mst_bridge.sv | 147 ++++++++++++++
 tb/tb_axi4l_mst_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_mst_bridge_pkg.sv
// Shared definitions for the AXI4-Lite master bridge: response codes, FSM states,
// the default timeout and a response decode helper.
package axi4l_mst_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int TMO_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREQ,
        ST_WRESP,
        ST_RREQ,
        ST_RRESP,
        ST_DONE
    } state_t;

    // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
    function automatic logic respIsErr(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4l_mst_bridge_if.sv
// AXI4-Lite bus bundle between the bridge (master) and a fabric slave.
interface axi4l_mst_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface

// File: rtl/axi4l_mst_bridge.sv
// Single-outstanding AXI4-Lite master: turns a core req/gnt port into AW+W or AR
// transactions, with a saturating timeout that forces an error response.
module axi4l_mst_bridge
    import axi4l_mst_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = TMO_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic                gnt_o,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    axi4l_mst_bridge_if.master  m_axi
);

    localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
    localparam bit TMO_EN = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = (TMO_CYC == 0) ? '0 : TMO_W'(TMO_CYC - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_awDone;
    logic                r_wDone;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_rspValid;
    logic [TMO_W-1:0]    r_tmo;

    logic w_awHs;
    logic w_wHs;
    logic w_bHs;
    logic w_arHs;
    logic w_rHs;
    logic w_inWait;
    logic w_tmoHit;

    assign gnt_o  = req_i & (r_state == ST_IDLE);
    assign busy_o = (r_state != ST_IDLE);

    assign m_axi.awaddr  = r_addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = (r_state == ST_WREQ) & ~r_awDone;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.wvalid  = (r_state == ST_WREQ) & ~r_wDone;
    assign m_axi.bready  = (r_state == ST_WRESP);
    assign m_axi.araddr  = r_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = (r_state == ST_RREQ);
    assign m_axi.rready  = (r_state == ST_RRESP);

    assign w_awHs = m_axi.awvalid & m_axi.awready;
    assign w_wHs  = m_axi.wvalid & m_axi.wready;
    assign w_bHs  = m_axi.bready & m_axi.bvalid;
    assign w_arHs = m_axi.arvalid & m_axi.arready;
    assign w_rHs  = m_axi.rready & m_axi.rvalid;

    // Timeout only applies while waiting on the fabric, never in DONE.
    assign w_inWait = (r_state == ST_WREQ) || (r_state == ST_WRESP) ||
                      (r_state == ST_RREQ) || (r_state == ST_RRESP);
    assign w_tmoHit = TMO_EN && w_inWait && (r_tmo == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // AW and W may complete in either order; the done flags remember the earlier one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_i) w_next = we_i ? ST_WREQ : ST_RREQ;
            ST_WREQ:  if ((r_awDone | w_awHs) & (r_wDone | w_wHs)) w_next = ST_WRESP;
            ST_WRESP: if (w_bHs) w_next = ST_DONE;
            ST_RREQ:  if (w_arHs) w_next = ST_RRESP;
            ST_RRESP: if (w_rHs) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_tmoHit) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awDone   <= 1'b0;
            r_wDone    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_rspValid <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_rspValid <= 1'b0;
            if (gnt_o) begin
                r_addr   <= addr_i;
                r_wdata  <= wdata_i;
                r_wstrb  <= wstrb_i;
                r_awDone <= 1'b0;
                r_wDone  <= 1'b0;
                r_tmo    <= '0;
            end else begin
                if (busy_o && (r_tmo != {TMO_W{1'b1}})) begin
                    r_tmo <= r_tmo + 1'b1;
                end
                if (w_awHs) r_awDone <= 1'b1;
                if (w_wHs)  r_wDone  <= 1'b1;
            end

            if (w_tmoHit) begin
                r_rspValid <= 1'b1;
                r_err      <= 1'b1;
                r_rdata    <= '0;
            end else if (w_bHs) begin
                r_rspValid <= 1'b1;
                r_err      <= respIsErr(m_axi.bresp);
            end else if (w_rHs) begin
                r_rspValid <= 1'b1;
                r_err      <= respIsErr(m_axi.rresp);
                r_rdata    <= m_axi.rdata;
            end
        end
    end

    assign rsp_valid_o = r_rspValid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_axi4l_mst_bridge.sv
// Self-checking bench for axi4l_mst_bridge: configurable slave model, response
// scoreboard, a vector table and hand-written multi-cycle sequences.
module tb_axi4l_mst_bridge;
    import axi4l_mst_bridge_pkg::*;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        gnt_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    axi4l_mst_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi4l_mst_bridge #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .wstrb_i    (wstrb_i),
        .gnt_o      (gnt_o),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .busy_o     (busy_o),
        .m_axi      (axi.master)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          awDly;
        int          wDly;
        int          bDly;
        int          arDly;
        int          rDly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          arNever;
        bit          bStuck;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          gntCyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        monE;
    vec_t        table_v[8];
    vec_t        hv;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rspCount = 0;
    int          rspBase;
    logic [31:0] lastRdata = 32'h0;

    int          cfgAwDly = 0, cfgWDly = 0, cfgBDly = 0, cfgArDly = 0, cfgRDly = 0;
    bit          cfgArNever = 0, cfgBStuck = 0;
    logic [1:0]  cfgResp = 2'b00;
    logic [31:0] cfgRdata = 32'h0;
    logic [31:0] curAddr = 32'h0, curWdata = 32'h0;
    logic [3:0]  curWstrb = 4'h0;
    int          awCnt = 0, wCnt = 0, bCnt = 0, arCnt = 0, rCnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: readies/valids are decided on the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
            axi.arready = 1'b0; axi.rvalid = 1'b0;
            awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
        end else begin
            if (axi.awvalid) begin axi.awready = (awCnt == cfgAwDly); awCnt++; end
            else begin axi.awready = 1'b0; awCnt = 0; end
            if (axi.wvalid) begin axi.wready = (wCnt == cfgWDly); wCnt++; end
            else begin axi.wready = 1'b0; wCnt = 0; end
            if (axi.bready) begin axi.bvalid = cfgBStuck || (bCnt == cfgBDly); bCnt++; end
            else begin axi.bvalid = cfgBStuck; bCnt = 0; end
            if (axi.arvalid) begin axi.arready = !cfgArNever && (arCnt == cfgArDly); arCnt++; end
            else begin axi.arready = 1'b0; arCnt = 0; end
            if (axi.rready) begin axi.rvalid = (rCnt == cfgRDly); rCnt++; end
            else begin axi.rvalid = 1'b0; rCnt = 0; end
        end
        axi.bresp = cfgResp;
        axi.rresp = cfgResp;
        axi.rdata = axi.rvalid ? cfgRdata : 32'hBAD0_BAD0;
        if (!rst && axi.awvalid && axi.awready) begin
            checkOutput("awaddr", axi.awaddr, curAddr);
            checkOutput("awprot", 32'(axi.awprot), 32'h0);
        end
        if (!rst && axi.wvalid && axi.wready) begin
            checkOutput("wdata", axi.wdata, curWdata);
            checkOutput("wstrb", 32'(axi.wstrb), 32'(curWstrb));
        end
        if (!rst && axi.arvalid && axi.arready) begin
            checkOutput("araddr", axi.araddr, curAddr);
            checkOutput("arprot", 32'(axi.arprot), 32'h0);
        end
    end

    // Response monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid_o) begin
            rspCount++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_rsp: got rsp_valid_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                monE = sb.pop_front();
                checkOutput("rsp_err", 32'(rsp_err_o), 32'(monE.err));
                checkOutput("rsp_rdata", rsp_rdata_o, monE.rdata);
                checkOutput("rsp_latency", 32'(cyc - monE.gntCyc), 32'(monE.lat));
            end
        end
    end

    function automatic vec_t mkVec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] wstrb, input int awD, input int wD, input int bD,
                                   input int arD, input int rD, input logic [1:0] resp,
                                   input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.awDly = awD; v.wDly = wD; v.bDly = bD; v.arDly = arD; v.rDly = rD;
        v.resp = resp; v.rdata = rdata; v.arNever = 1'b0; v.bStuck = 1'b0;
        return v;
    endfunction

    // Drives one request, waits for the grant and pushes the modelled response.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   waited;
        int   lat;
        bit   tmo;
        cfgAwDly = v.awDly; cfgWDly = v.wDly; cfgBDly = v.bDly;
        cfgArDly = v.arDly; cfgRDly = v.rDly; cfgArNever = v.arNever;
        cfgBStuck = v.bStuck; cfgResp = v.resp; cfgRdata = v.rdata;
        curAddr = v.addr; curWdata = v.wdata; curWstrb = v.wstrb;
        @(negedge clk);
        req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; wstrb_i = v.wstrb;
        #1;
        waited = 0;
        while (!gnt_o && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("gnt", 32'(gnt_o), 32'h1);
        if (!gnt_o) begin
            req_i = 1'b0;
            return;
        end
        if (v.we) lat = 3 + ((v.awDly > v.wDly) ? v.awDly : v.wDly) + (v.bStuck ? 0 : v.bDly);
        else      lat = 3 + v.arDly + v.rDly;
        tmo = (!v.we && v.arNever) || (lat > TMO);
        e.gntCyc = cyc;
        if (tmo) begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = TMO + 1; lastRdata = 32'h0;
        end else if (v.we) begin
            e.err = v.resp[1]; e.rdata = lastRdata; e.lat = lat;
        end else begin
            e.err = v.resp[1]; e.rdata = v.rdata; e.lat = lat; lastRdata = v.rdata;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_i = 1'b0;
    endtask

    task automatic waitResponse(input int startCount);
        int n;
        n = 0;
        while (rspCount == startCount && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (rspCount == startCount) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_wait: got no rsp_valid_o within 40 cycles, expected a response");
            sb.delete();
        end
    endtask

    initial begin
        logic [4:0] awPat, wPat, bPat;
        int         arHigh, rHigh;

        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy_o), 32'h0);
        checkOutput("reset_gnt", 32'(gnt_o), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        checkOutput("reset_rsp_err", 32'(rsp_err_o), 32'h0);
        checkOutput("reset_rdata", rsp_rdata_o, 32'h0);
        checkOutput("reset_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid}), 32'h0);
        checkOutput("reset_readies", 32'({axi.bready, axi.rready}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // First transaction: zero-wait write, handshake visible in T1.
        rspBase = rspCount;
        applyStimulus(mkVec(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY, 32'h0));
        checkOutput("t1_awvalid", 32'(axi.awvalid), 32'h1);
        checkOutput("t1_wvalid", 32'(axi.wvalid), 32'h1);
        checkOutput("t1_busy", 32'(busy_o), 32'h1);
        waitResponse(rspBase);

        table_v[0] = mkVec(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, RESP_OKAY, 32'hCAFE_F00D);
        table_v[1] = mkVec(1'b1, 32'h0000_0044, 32'h0000_A5A5, 4'h3, 2, 1, 1, 0, 0, RESP_EXOKAY, 32'h0);
        table_v[2] = mkVec(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 1, 1, RESP_DECERR, 32'h8765_4321);
        table_v[3] = mkVec(1'b1, 32'h0000_0200, 32'h1111_2222, 4'h8, 0, 0, 0, 0, 0, RESP_SLVERR, 32'h0);
        table_v[4] = mkVec(1'b0, 32'h0000_0304, 32'h0, 4'h0, 0, 0, 0, 0, 2, RESP_OKAY, 32'h0F0F_0F0F);
        table_v[5] = mkVec(1'b1, 32'h0000_0408, 32'h5555_AAAA, 4'hF, 1, 0, 0, 0, 0, RESP_OKAY, 32'h0);
        table_v[6] = mkVec(1'b1, 32'h0000_050C, 32'h7777_8888, 4'hC, 0, 0, 20, 0, 0, RESP_OKAY, 32'h0);
        table_v[7] = mkVec(1'b0, 32'h0000_0600, 32'h0, 4'h0, 0, 0, 0, 0, 0, RESP_EXOKAY, 32'h1357_9BDF);
        for (int i = 0; i < 8; i++) begin
            rspBase = rspCount;
            applyStimulus(table_v[i]);
            waitResponse(rspBase);
        end

        // awready at T1, wready at T4: W side held alone until T4, WRESP from T5.
        awPat = 5'b00001; wPat = 5'b01111; bPat = 5'b10000;
        rspBase = rspCount;
        applyStimulus(mkVec(1'b1, 32'h0000_0700, 32'hA1B2_C3D4, 4'hF, 0, 3, 0, 0, 0, RESP_OKAY, 32'h0));
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("split_awvalid_T%0d", k + 1), 32'(axi.awvalid), 32'(awPat[k]));
            checkOutput($sformatf("split_wvalid_T%0d", k + 1), 32'(axi.wvalid), 32'(wPat[k]));
            checkOutput($sformatf("split_bready_T%0d", k + 1), 32'(axi.bready), 32'(bPat[k]));
            @(posedge clk);
            #1;
        end
        waitResponse(rspBase);

        // Slow read: arvalid held three cycles, rready held two.
        arHigh = 0; rHigh = 0;
        rspBase = rspCount;
        applyStimulus(mkVec(1'b0, 32'h0000_0800, 32'h0, 4'h0, 0, 0, 0, 2, 1, RESP_OKAY, 32'h1234_5678));
        for (int k = 0; k < 7; k++) begin
            if (axi.arvalid) arHigh++;
            if (axi.rready) rHigh++;
            @(posedge clk);
            #1;
        end
        checkOutput("slow_read_arvalid_cycles", 32'(arHigh), 32'd3);
        checkOutput("slow_read_rready_cycles", 32'(rHigh), 32'd2);
        waitResponse(rspBase);
        checkOutput("slow_read_rdata_held", rsp_rdata_o, 32'h1234_5678);

        // bvalid stuck high while idle must not produce a response.
        cfgBStuck = 1'b1; cfgResp = RESP_SLVERR;
        rspBase = rspCount;
        repeat (6) @(negedge clk);
        #2;
        checkOutput("stuck_b_no_rsp", 32'(rspCount - rspBase), 32'h0);
        checkOutput("stuck_b_idle", 32'(busy_o), 32'h0);
        hv = mkVec(1'b1, 32'h0000_0900, 32'hFEED_FACE, 4'h1, 0, 0, 5, 0, 0, RESP_SLVERR, 32'h0);
        hv.bStuck = 1'b1;
        applyStimulus(hv);
        waitResponse(rspBase);
        cfgBStuck = 1'b0;
        @(negedge clk);

        // Read that is never accepted: timeout response, bus released.
        hv = mkVec(1'b0, 32'h0000_0A00, 32'h0, 4'h0, 0, 0, 0, 0, 0, RESP_OKAY, 32'h0);
        hv.arNever = 1'b1;
        rspBase = rspCount;
        applyStimulus(hv);
        waitResponse(rspBase);
        checkOutput("tmo_arvalid_low", 32'(axi.arvalid), 32'h0);
        checkOutput("tmo_idle", 32'(busy_o), 32'h0);

        // Reset while waiting on B: everything clears, no response ever appears.
        rspBase = rspCount;
        applyStimulus(mkVec(1'b1, 32'h0000_0B00, 32'h0BAD_CAFE, 4'hF, 0, 0, 30, 0, 0, RESP_OKAY, 32'h0));
        for (int k = 0; k < 10 && !axi.bready; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_mid_in_wresp", 32'(axi.bready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_mid_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid}), 32'h0);
        checkOutput("rst_mid_readies", 32'({axi.bready, axi.rready}), 32'h0);
        checkOutput("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'h0);
        checkOutput("rst_mid_rsp_err", 32'(rsp_err_o), 32'h0);
        checkOutput("rst_mid_rdata", rsp_rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        lastRdata = 32'h0;
        repeat (12) @(negedge clk);
        #2;
        checkOutput("rst_mid_no_late_rsp", 32'(rspCount - rspBase), 32'h0);
        rspBase = rspCount;
        applyStimulus(mkVec(1'b0, 32'h0000_0C00, 32'h0, 4'h0, 0, 0, 0, 0, 0, RESP_OKAY, 32'h2468_ACE0));
        waitResponse(rspBase);
        @(negedge clk);
        @(negedge clk);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
